// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register-bus slave: instruction codes, status
// bit positions, frame edge numbers and the frame FSM state type.
package spi_reg_pkg;
  localparam logic [7:0] INSTR_WRITE = 8'h00;
  localparam logic [7:0] INSTR_READ  = 8'h01;

  localparam int ST_DONE    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_INVALID = 3;

  // Rising-edge numbers that close each phase; *_FALL are falling-edge loads
  localparam logic [6:0] E_CMD_LAST   = 7'd8;
  localparam logic [6:0] E_GAP        = 7'd9;
  localparam logic [6:0] E_ADDR_LAST  = 7'd41;
  localparam logic [6:0] E_WDATA_LAST = 7'd73;
  localparam logic [6:0] E_DATA_FALL  = 7'd48;
  localparam logic [6:0] E_STAT_FALL  = 7'd80;
  localparam logic [6:0] E_LAST       = 7'd88;

  typedef enum logic [2:0] {
    IDLE, CMD, GAP, ADDR, WDATA, ACCESS, SHIFT_OUT, WAIT_SS
  } state_e;
endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous input, with a third flop for
// rise/fall detection; q_d is the synchronised value one clk older than q.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_d,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end

  assign q    = s2;
  assign q_d  = s3;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that turns 0x00/0x01 frames into single register-bus
// writes/reads and returns read data plus a status byte on MISO.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic sck_rise, sck_fall, ss_n, mosi_d;
  logic unused_sck_q, unused_sck_qd, unused_ss_qd, unused_ss_rise, unused_ss_fall;
  logic unused_mosi_q, unused_mosi_rise, unused_mosi_fall;

  spi_sync #(.RST_VAL(1'b0)) u_sck (.clk(clk), .rst(rst), .d(spi_sck), .q(unused_sck_q),
    .q_d(unused_sck_qd), .rise(sck_rise), .fall(sck_fall));
  spi_sync #(.RST_VAL(1'b1)) u_ss (.clk(clk), .rst(rst), .d(spi_ss_n), .q(ss_n),
    .q_d(unused_ss_qd), .rise(unused_ss_rise), .fall(unused_ss_fall));
  spi_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(unused_mosi_q),
    .q_d(mosi_d), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  state_e          state_q, state_d;
  logic [6:0]      cnt, edge_n;
  logic [31:0]     sh, sh_nxt, addr_q, rdata_q, miso_sr;
  logic [7:0]      instr_q, status;
  logic            st_done, st_err, st_to, invalid;
  logic            acc_rd, acc_wr, bus_fin;
  logic [TW-1:0]   tmr;

  assign edge_n  = cnt + 7'd1;
  assign sh_nxt  = {sh[30:0], mosi_d};
  assign invalid = (instr_q != INSTR_WRITE) && (instr_q != INSTR_READ);
  assign bus_fin = bus_req & (bus_ack | bus_err | (tmr == TW'(TIMEOUT_CYC - 1)));
  assign spi_miso = miso_sr[31];

  always_comb begin
    status = '0;
    if (invalid) status[ST_INVALID] = 1'b1;
    else begin
      status[ST_TIMEOUT] = st_to;
      status[ST_ERR]     = st_err;
      status[ST_DONE]    = st_done;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    if (ss_n) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:  state_d = CMD;
        CMD:   if (sck_rise && edge_n == E_CMD_LAST) state_d = GAP;
        GAP:   if (sck_rise && edge_n == E_GAP) state_d = ADDR;
        ADDR:  if (sck_rise && edge_n == E_ADDR_LAST) begin
          if (instr_q == INSTR_WRITE) state_d = WDATA;
          else if (instr_q == INSTR_READ) begin
            state_d = ACCESS;
            acc_rd  = 1'b1;
          end else state_d = SHIFT_OUT;
        end
        WDATA: if (sck_rise && edge_n == E_WDATA_LAST) begin
          state_d = ACCESS;
          acc_wr  = 1'b1;
        end
        ACCESS:    if (bus_fin) state_d = SHIFT_OUT;
        SHIFT_OUT: if (sck_rise && edge_n == E_LAST) state_d = WAIT_SS;
        default:   state_d = state_q;
      endcase
    end
  end

  // Frame datapath: edge counter, input shifter, response shifter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      sh      <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      miso_sr <= '0;
    end else begin
      if (ss_n) begin
        cnt <= '0;
        sh  <= '0;
      end else if (sck_rise) begin
        if (cnt != 7'h7f) cnt <= edge_n;
        sh <= sh_nxt;
        if (state_q == CMD && edge_n == E_CMD_LAST) instr_q <= sh_nxt[7:0];
        if (state_q == ADDR && edge_n == E_ADDR_LAST) addr_q <= sh_nxt;
      end
      if (state_q != ACCESS && state_q != SHIFT_OUT) miso_sr <= '0;
      else if (sck_fall) begin
        if (cnt == E_DATA_FALL)      miso_sr <= (instr_q == INSTR_READ) ? rdata_q : '0;
        else if (cnt == E_STAT_FALL) miso_sr <= {status, 24'h0};
        else                         miso_sr <= {miso_sr[30:0], 1'b0};
      end
    end

  // Bus engine runs independently of the frame so an aborted access still completes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      tmr       <= '0;
      rdata_q   <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      st_to     <= 1'b0;
    end else if (bus_req) begin
      tmr <= tmr + TW'(1);
      if (bus_fin) begin
        bus_req <= 1'b0;
        st_err  <= bus_err;
        st_done <= bus_ack & ~bus_err;
        st_to   <= ~bus_ack & ~bus_err;
        rdata_q <= (bus_ack & ~bus_err) ? bus_rdata : '0;
      end
    end else if (acc_rd | acc_wr) begin
      bus_req  <= 1'b1;
      bus_we   <= acc_wr;
      bus_addr <= acc_wr ? addr_q : sh_nxt;
      if (acc_wr) bus_wdata <= sh_nxt;
      tmr      <= '0;
      rdata_q  <= '0;
      st_done  <= 1'b0;
      st_err   <= 1'b0;
      st_to    <= 1'b0;
    end
endmodule
